// File: rtl/alu_pkg.sv
// Shared definitions for the accumulator ALU: opcode encoding and default width.
package alu_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // Opcode encoding shared with the controller; values are fixed at 0..7.
    typedef enum logic [2:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_t;

endpackage : alu_pkg

// File: rtl/alu.sv
// Accumulator ALU: computes the next accumulator value from accum, data and
// opcode, and registers it on the falling edge of clk. The falling edge lets
// the result settle mid-cycle so the controller can pick it up on the
// following rising edge. The zero flag looks at accum directly and does not
// depend on the register.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] accum,
    input  logic [WIDTH-1:0] data,
    input  opcode_t          opcode,
    output logic [WIDTH-1:0] out,
    output logic             zero
);

    logic [WIDTH-1:0] next_out;

    // Next-value selection; opcodes without an arithmetic role pass accum through.
    always_comb begin
        // NOTE: next_out gets a value on every path (default first, plus a
        // default branch), so no latch is inferred even for X or unknown opcodes.
        next_out = accum;
        unique case (opcode)
            HLT:     next_out = accum;
            SKZ:     next_out = accum;
            ADD:     next_out = accum + data;   // carry out is dropped
            AND:     next_out = accum & data;
            XOR:     next_out = accum ^ data;
            LDA:     next_out = data;
            STO:     next_out = accum;
            JMP:     next_out = accum;
            default: next_out = accum;
        endcase
    end

    // Result register on the falling edge; reset overrides any operation.
    always_ff @(negedge clk) begin
        // NOTE: reset is synchronous here (sampled on the same edge as the data),
        // and state is updated with non-blocking assignments so every reader of
        // out sees the pre-edge value within the same time step.
        if (!rst_n) begin
            out <= '0;
        end else begin
            out <= next_out;
        end
    end

    // Skip-if-zero flag follows accum combinationally, including during reset.
    assign zero = (accum == '0);

endmodule : alu

// File: tb/tb_alu.sv
// Directed self-checking bench for the accumulator ALU. Inputs change just
// after a rising edge, the ALU registers on the falling edge, and outputs are
// checked one tick after the following rising edge.
module tb_alu;
    import alu_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] accum;
    logic [W-1:0] data;
    opcode_t      opcode;
    logic [W-1:0] out;
    logic         zero;

    int vectors = 0;
    int miscompares = 0;

    alu #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .accum  (accum),
        .data   (data),
        .opcode (opcode),
        .out    (out),
        .zero   (zero)
    );

    // 10-unit clock: rising edges at 5, 15, ...; falling edges at 10, 20, ...
    always #5 clk = ~clk;

    // Watchdog so the run can never hang.
    initial begin
        #50000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "simulation time limit reached");
    end

    task automatic check(input string tag, input logic [W-1:0] observed,
                         input logic [W-1:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Drive one operation, let the falling edge register it, then move to
    // just after the next rising edge where the result is checked.
    task automatic step(input opcode_t op, input logic [W-1:0] d,
                        input logic [W-1:0] a);
        opcode = op;
        data   = d;
        accum  = a;
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held across a falling edge with an ADD pending.
        rst_n = 1'b0;
        step(ADD, 8'h37, 8'hDA);
        check("reset_out", out, 8'h00);
        check("reset_zero", {7'b0, zero}, 8'h00);

        // Release reset: the same ADD completes on the next falling edge.
        rst_n = 1'b1;
        step(ADD, 8'h37, 8'hDA);
        check("post_reset_add", out, 8'h11);

        // Opcode sweep with data=37, accum=DA.
        step(HLT, 8'h37, 8'hDA); check("hlt", out, 8'hDA); check("hlt_zero", {7'b0, zero}, 8'h00);
        step(SKZ, 8'h37, 8'hDA); check("skz", out, 8'hDA); check("skz_zero", {7'b0, zero}, 8'h00);
        step(ADD, 8'h37, 8'hDA); check("add", out, 8'h11); check("add_zero", {7'b0, zero}, 8'h00);
        step(AND, 8'h37, 8'hDA); check("and", out, 8'h12); check("and_zero", {7'b0, zero}, 8'h00);
        step(XOR, 8'h37, 8'hDA); check("xor", out, 8'hED); check("xor_zero", {7'b0, zero}, 8'h00);
        step(LDA, 8'h37, 8'hDA); check("lda", out, 8'h37); check("lda_zero", {7'b0, zero}, 8'h00);
        step(STO, 8'h37, 8'hDA); check("sto", out, 8'hDA); check("sto_zero", {7'b0, zero}, 8'h00);

        // Zero flag follows accum, not out.
        step(JMP, 8'h37, 8'h00); check("jmp_acc0", out, 8'h00); check("jmp_zero", {7'b0, zero}, 8'h01);
        step(LDA, 8'h72, 8'h00); check("lda_acc0", out, 8'h72); check("lda_acc0_zero", {7'b0, zero}, 8'h01);

        // Arithmetic and logic values.
        step(ADD, 8'h12, 8'h07); check("add_07_12", out, 8'h19);
        step(AND, 8'h35, 8'h1F); check("and_1f_35", out, 8'h15);
        step(XOR, 8'h1D, 8'h1E); check("xor_1e_1d", out, 8'h03);
        step(ADD, 8'h01, 8'hFF); check("add_wrap", out, 8'h00); check("add_wrap_zero", {7'b0, zero}, 8'h00);

        // Unknown opcode passes accum through.
        step(opcode_t'(3'bxxx), 8'h33, 8'h5A); check("x_opcode", out, 8'h5A);

        // Reset mid-operation discards the result; zero still valid in reset.
        rst_n = 1'b0;
        step(LDA, 8'h55, 8'h00); check("midop_reset_out", out, 8'h00); check("reset_zero_acc0", {7'b0, zero}, 8'h01);
        rst_n = 1'b1;
        step(LDA, 8'h55, 8'h00); check("resume_lda", out, 8'h55);

        // STO then accum drops to zero mid-cycle: zero reacts at once, out waits.
        step(STO, 8'h00, 8'h10); check("sto_10", out, 8'h10); check("sto_10_zero", {7'b0, zero}, 8'h00);
        accum = 8'h00;
        #1;
        check("midcycle_zero", {7'b0, zero}, 8'h01);
        check("midcycle_out_held", out, 8'h10);
        @(negedge clk);
        #1;
        check("after_fall_out", out, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_alu
